// File: rtl/cmd_interp_pkg.sv
// Shared opcodes, FSM states and command-word field offsets
// for the multi-channel command interpreter.
package cmd_interp_pkg;

    localparam logic [15:0] FPGA_TERMINATE_CMD    = 16'h0001;
    localparam logic [15:0] START_JOB_MANAGER_CMD = 16'h0002;
    localparam logic [15:0] STOP_JOB_MANAGER_CMD  = 16'h0003;
    localparam logic [15:0] UPDATE_JOB_CONFIG_CMD = 16'h0004;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        RST_PULSE
    } state_t;

    localparam int OP_LSB       = 0;
    localparam int POLL_LSB     = 16;
    localparam int SIZE_LSB     = 32;
    localparam int MASK_LSB     = 64;
    localparam int SLOT_LSB     = 128;
    localparam int SLOT_STRIDE  = 64;
    localparam int SLOT_CFG_OFF = 32;

endpackage

// File: rtl/cmd_interpreter_mc_slot.sv
// One job channel: base/config registers plus the config
// valid/ready handshake flag.
module cfg_handshake_slot (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_base,
    input  logic        load_cfg,
    input  logic        drop,
    input  logic        clear,
    input  logic [31:0] base_in,
    input  logic [15:0] cfg_in,
    input  logic        ready,
    output logic [31:0] base,
    output logic [15:0] cfg,
    output logic        valid,
    output logic        pending
);

    // Still owed an ack after the coming edge.
    assign pending = valid && !ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base  <= '0;
            cfg   <= '0;
            valid <= 1'b0;
        end else begin
            if (clear) begin
                base <= '0;
                cfg  <= '0;
            end else begin
                if (load_base) base <= base_in;
                if (load_cfg)  cfg  <= cfg_in;
            end
            if (drop)
                valid <= 1'b0;
            else if (load_cfg)
                valid <= 1'b1;
            else if (valid && ready)
                valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cmd_interpreter_mc.sv
// Multi-channel shell command decoder: pops commands, drives job
// reader enable, per-channel configs and a timed DSM reset pulse.
module cmd_interpreter_mc
    import cmd_interp_pkg::*;
#(
    parameter int NUM_JOB_TYPES      = 4,
    parameter int CMD_WIDTH          = 512,
    parameter int PTE_WIDTH          = 20,
    parameter int RESET_PULSE_CYCLES = 4,
    parameter int ERR_CNT_WIDTH      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PTE_WIDTH-1:0]        first_page_address,
    input  logic [CMD_WIDTH-1:0]        cmd_queue_out,
    input  logic                        cmd_queue_valid,
    output logic                        cmd_queue_ready,
    output logic                        dsm_reset,
    output logic                        job_reader_enable,
    output logic [31:0]                 job_queue_size,
    output logic [15:0]                 queue_poll_rate,
    output logic [32*NUM_JOB_TYPES-1:0] job_queue_base_addr,
    output logic [16*NUM_JOB_TYPES-1:0] job_config,
    output logic [NUM_JOB_TYPES-1:0]    job_config_valid,
    input  logic [NUM_JOB_TYPES-1:0]    job_config_ready,
    output logic [ERR_CNT_WIDTH-1:0]    unknown_cmd_count,
    output logic                        cmd_busy
);

    localparam int LW = 32 - PTE_WIDTH;
    localparam int CW = (RESET_PULSE_CYCLES > 1) ?
                        $clog2(RESET_PULSE_CYCLES) : 1;

    if (SLOT_LSB + SLOT_STRIDE * NUM_JOB_TYPES > CMD_WIDTH) begin : g_bad_width
        $error("CMD_WIDTH too small for NUM_JOB_TYPES slots");
    end
    if (RESET_PULSE_CYCLES < 1) begin : g_bad_pulse
        $error("RESET_PULSE_CYCLES must be >= 1");
    end

    state_t                   state, state_next;
    logic [15:0]              opcode;
    logic [NUM_JOB_TYPES-1:0] mask, pending;
    logic [CW-1:0]            pulse_cnt;
    logic                     accept, pulse_done;
    logic                     is_term, is_start, is_stop, is_update, is_unknown;
    logic                     unused_cmd;

    assign unused_cmd      = ^cmd_queue_out;
    assign opcode          = cmd_queue_out[OP_LSB +: 16];
    assign mask            = cmd_queue_out[MASK_LSB +: NUM_JOB_TYPES];
    assign cmd_queue_ready = (state == IDLE) && !rst;
    assign accept          = cmd_queue_valid && cmd_queue_ready;
    assign cmd_busy        = (state != IDLE);
    assign pulse_done      = (state == RST_PULSE) &&
                             (pulse_cnt == CW'(RESET_PULSE_CYCLES - 1));

    always_comb begin
        is_term    = 1'b0;
        is_start   = 1'b0;
        is_stop    = 1'b0;
        is_update  = 1'b0;
        is_unknown = 1'b0;
        if (accept) begin
            unique case (opcode)
                FPGA_TERMINATE_CMD:    is_term    = 1'b1;
                START_JOB_MANAGER_CMD: is_start   = 1'b1;
                STOP_JOB_MANAGER_CMD:  is_stop    = 1'b1;
                UPDATE_JOB_CONFIG_CMD: is_update  = 1'b1;
                default:               is_unknown = 1'b1;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (is_term)
                    state_next = RST_PULSE;
                else if ((is_start || is_update) && |mask)
                    state_next = WAIT_ACK;
            end
            WAIT_ACK:  if (!(|pending)) state_next = IDLE;
            RST_PULSE: if (pulse_done)  state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pulse_cnt         <= '0;
            dsm_reset         <= 1'b0;
            job_reader_enable <= 1'b0;
            job_queue_size    <= '0;
            queue_poll_rate   <= '0;
            unknown_cmd_count <= '0;
        end else begin
            if (is_term) begin
                dsm_reset         <= 1'b1;
                job_reader_enable <= 1'b0;
                pulse_cnt         <= '0;
            end else if (state == RST_PULSE) begin
                if (pulse_done) dsm_reset <= 1'b0;
                else            pulse_cnt <= pulse_cnt + CW'(1);
            end
            if (is_start) begin
                job_reader_enable <= 1'b1;
                job_queue_size    <= cmd_queue_out[SIZE_LSB +: 32];
                queue_poll_rate   <= cmd_queue_out[POLL_LSB +: 16];
            end
            if (is_stop) job_reader_enable <= 1'b0;
            if (pulse_done) begin
                job_queue_size  <= '0;
                queue_poll_rate <= '0;
            end
            if (is_unknown && unknown_cmd_count != '1)
                unknown_cmd_count <= unknown_cmd_count + ERR_CNT_WIDTH'(1);
        end
    end

    for (genvar j = 0; j < NUM_JOB_TYPES; j++) begin : g_slot
        localparam int SB = SLOT_LSB + SLOT_STRIDE * j;
        cfg_handshake_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .load_base (is_start && mask[j]),
            .load_cfg  ((is_start || is_update) && mask[j]),
            .drop      (is_term),
            .clear     (pulse_done),
            .base_in   ({first_page_address, cmd_queue_out[SB +: LW]}),
            .cfg_in    (cmd_queue_out[SB + SLOT_CFG_OFF +: 16]),
            .ready     (job_config_ready[j]),
            .base      (job_queue_base_addr[32*j +: 32]),
            .cfg       (job_config[16*j +: 16]),
            .valid     (job_config_valid[j]),
            .pending   (pending[j])
        );
    end

endmodule
